// File: rtl/cpu_instr_sequencer_if.sv
// Bus bundle between cpu_instr_sequencer (slave) and whoever loads, starts and
// consumes its instruction stream (master).
// trace_sig exists only when TRACE_CHECKSUM_EN is defined.
interface cpu_instr_sequencer_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 64
);
  localparam int AW = $clog2(DEPTH);

  logic            load_we;
  logic [AW-1:0]   load_addr;
  logic [XLEN-1:0] load_data;
  logic            start;
  logic            cpu_ready;
  logic [XLEN-1:0] instr_out;
  logic            instr_valid;
  logic [AW-1:0]   pc_out;
  logic            busy;
  logic            done;
  logic            timeout;
  logic [31:0]     retired_count;
  logic [31:0]     cycle_count;
`ifdef TRACE_CHECKSUM_EN
  logic [XLEN-1:0] trace_sig;
`endif

  modport master (
    output load_we, load_addr, load_data, start, cpu_ready,
    input  instr_out, instr_valid, pc_out, busy, done, timeout,
           retired_count, cycle_count
`ifdef TRACE_CHECKSUM_EN
    , input trace_sig
`endif
  );

  modport slave (
    input  load_we, load_addr, load_data, start, cpu_ready,
    output instr_out, instr_valid, pc_out, busy, done, timeout,
           retired_count, cycle_count
`ifdef TRACE_CHECKSUM_EN
    , output trace_sig
`endif
  );
endinterface

// File: rtl/cpu_instr_sequencer.sv
// Instruction source for the single-cycle core: a small program image streamed
// one word per accepted cycle, stopping on HALT_WORD, end of image, or when the
// RUN cycle budget runs out. Retired instructions and RUN cycles are counted.
// Optional macro TRACE_CHECKSUM_EN adds a rotate-xor signature of issued words.
module cpu_instr_sequencer #(
  parameter int              XLEN       = 32,
  parameter int              DEPTH      = 64,
  parameter int              MAX_CYCLES = 1024,
  parameter logic [XLEN-1:0] HALT_WORD  = 'h0000_0073
) (
  input logic                 clk,
  input logic                 rst,
  cpu_instr_sequencer_if.slave bus
);
  localparam int              AW        = $clog2(DEPTH);
  localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [31:0]     CYC_LIMIT = 32'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_DONE    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [XLEN-1:0] r_image [DEPTH];
  logic [AW-1:0]   r_pc;
  logic [31:0]     r_retired;
  logic [31:0]     r_cycles;

  logic [XLEN-1:0] w_instr;
  logic            w_run;
  logic            w_issue;
  logic            w_stop;
  logic            w_budget;
  logic            w_launch;
  logic            w_load_ok;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign w_instr   = r_image[r_pc];
  assign w_run     = (r_state == S_RUN);
  assign w_issue   = w_run & bus.cpu_ready;
  // A halt word or the last image slot ends the run on the cycle it is issued.
  assign w_stop    = w_issue & ((w_instr == HALT_WORD) | (r_pc == LAST_ADDR));
  assign w_budget  = (r_cycles == CYC_LIMIT);
  assign w_launch  = ~w_run & bus.start;
  assign w_load_ok = bus.load_we & ~w_run & ~rst;

  // Program image: synchronous write, no reset so a rst keeps the loaded program.
  // NOTE: memories are left out of reset; clearing them would force a flop-based
  // array and the spec wants the image to survive rst anyway.
  always_ff @(posedge clk) begin
    if (w_load_ok) r_image[bus.load_addr] <= bus.load_data;
  end

  // State register.
  // NOTE: sequential state always uses non-blocking assignment so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic; end-of-run beats budget expiry on the same cycle.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_RUN: begin
        if (w_stop)        w_next_state = S_DONE;
        else if (w_budget) w_next_state = S_TIMEOUT;
      end
      default: begin
        if (bus.start)     w_next_state = S_RUN;
      end
    endcase
  end

  // Datapath: pc and saturating counters, cleared on rst or on a new run.
  always_ff @(posedge clk) begin
    if (rst || w_launch) begin
      r_pc      <= '0;
      r_retired <= '0;
      r_cycles  <= '0;
    end else if (w_run) begin
      r_cycles <= sat_inc(r_cycles);
      if (w_issue) begin
        r_retired <= sat_inc(r_retired);
        if (!w_stop) r_pc <= r_pc + AW'(1);
      end
    end
  end

`ifdef TRACE_CHECKSUM_EN
  logic [XLEN-1:0] r_trace;

  // Rotate-left-by-one then xor in each issued word; frozen outside RUN.
  always_ff @(posedge clk) begin
    if (rst || w_launch) r_trace <= '0;
    else if (w_issue)    r_trace <= {r_trace[XLEN-2:0], r_trace[XLEN-1]} ^ w_instr;
  end

  assign bus.trace_sig = r_trace;
`endif

  // Output decode: status flags follow the state, so done/timeout stay sticky.
  always_comb begin
    bus.busy        = (r_state == S_RUN);
    bus.done        = (r_state == S_DONE);
    bus.timeout     = (r_state == S_TIMEOUT);
    bus.instr_valid = (r_state == S_RUN);
  end

  assign bus.instr_out     = w_instr;
  assign bus.pc_out        = r_pc;
  assign bus.retired_count = r_retired;
  assign bus.cycle_count   = r_cycles;
endmodule
